fetch_unit: RTL

Instruction-fetch stage of the single-issue ARM-subset datapath, sitting directly upstream of the program ROM and the decoder. It holds the program counter, drives the ROM's 10-bit byte address, and captures each returned 32-bit instruction with its PC into a 2-entry queue. The queue is presented to decode through a valid/ready handshake. It also handles branch redirects, which flush the queue, and a run/stop control.

---
 rtl/fetch_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the single-issue ARM-subset datapath.
//
// Holds the program counter, drives the program ROM's byte address, and
// captures each returned instruction together with its PC tag into a
// 2-entry FIFO. Decode consumes the FIFO head through a valid/ready
// handshake. A taken branch (redirect) flushes the FIFO and reloads the PC.
// A small WAIT/RUN/STOP state machine gates fetching.
//
// Configuration macro: FETCH_PC8_EN
//   defined   -> the queued tag is pc + 8 (the ARM PC-read value)
//   undefined -> the queued tag is the raw fetch address pc
//
// Parameters:
//   RESET_PC    PC loaded on reset (bits [1:0] forced to 00)
//   ADDR_W      ROM byte-address width (low PC bits)
//
// Ports:
//   clock        in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   fetch_en     in   1 = fetch, 0 = stop fetching
//   rom_addr     out  ROM byte address, pc[ADDR_W-1:0], straight from the PC register
//   rom_data     in   ROM word at rom_addr (combinational read)
//   redirect     in   branch taken, from execute
//   redirect_pc  in   branch target (bits [1:0] forced to 00)
//   instr_valid  out  FIFO head is valid
//   instr        out  FIFO head instruction (0 when empty)
//   instr_pc     out  FIFO head PC tag (0 when empty)
//   dec_ready    in   decoder accepts the head this cycle
//   fetch_count  out  instructions pushed since reset, wrapping

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              dec_ready,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [31:0] PC_RESET_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  // Registered state
  state_t      state_r;
  logic [31:0] pc_r;
  logic [1:0]  count_r;
  logic [31:0] data0_r;   // FIFO head (oldest)
  logic [31:0] tag0_r;
  logic [31:0] data1_r;   // FIFO tail slot when two entries are held
  logic [31:0] tag1_r;
  logic [31:0] fetch_count_r;

  // Next-state values
  state_t      state_s;
  logic [31:0] pc_s;
  logic [1:0]  count_s;
  logic [31:0] data0_s;
  logic [31:0] tag0_s;
  logic [31:0] data1_s;
  logic [31:0] tag1_s;
  logic [31:0] fetch_count_s;

  logic        push_s;
  logic        pop_s;
  logic [31:0] tag_s;

  // Outputs come straight from registers. Empty slots are kept at zero so
  // instr/instr_pc read as zero whenever the queue is empty.
  assign rom_addr    = pc_r[ADDR_W-1:0];
  assign instr_valid = (count_r != 2'd0);
  assign instr       = data0_r;
  assign instr_pc    = tag0_r;
  assign fetch_count = fetch_count_r;

  // Tag stored alongside each fetched word
  always_comb begin
`ifdef FETCH_PC8_EN
    tag_s = pc_r + 32'd8;
`else
    tag_s = pc_r;
`endif
  end

  // Handshake qualifiers; redirect suppresses both push and pop
  always_comb begin
    pop_s  = instr_valid & dec_ready & ~redirect;
    push_s = (state_r == ST_RUN) & fetch_en & ~redirect &
             ((count_r != 2'd2) | pop_s);
  end

  // Run-control state machine: next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_WAIT: state_s = ST_RUN;
      ST_RUN: begin
        if (!fetch_en) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STOP: begin
        if (fetch_en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: state_s = ST_WAIT;
    endcase
  end

  // PC and push-counter next values
  always_comb begin
    pc_s          = pc_r;
    fetch_count_s = fetch_count_r;
    if (redirect) begin
      pc_s = redirect_pc & 32'hFFFF_FFFC;
    end else if (push_s) begin
      pc_s          = pc_r + 32'd4;
      fetch_count_s = fetch_count_r + 32'd1;
    end else begin
      pc_s          = pc_r;
      fetch_count_s = fetch_count_r;
    end
  end

  // FIFO next values: pop shifts the tail into the head, then a push lands
  // in the first free slot. A push is only allowed with a free slot after
  // the pop, so the post-pop count is at most 1 when pushing.
  always_comb begin
    count_s = count_r;
    data0_s = data0_r;
    tag0_s  = tag0_r;
    data1_s = data1_r;
    tag1_s  = tag1_r;
    if (redirect) begin
      count_s = 2'd0;
      data0_s = 32'h0000_0000;
      tag0_s  = 32'h0000_0000;
      data1_s = 32'h0000_0000;
      tag1_s  = 32'h0000_0000;
    end else begin
      if (pop_s) begin
        data0_s = data1_r;
        tag0_s  = tag1_r;
        data1_s = 32'h0000_0000;
        tag1_s  = 32'h0000_0000;
        count_s = count_r - 2'd1;
      end else begin
        count_s = count_r;
      end
      if (push_s) begin
        if (count_s == 2'd0) begin
          data0_s = rom_data;
          tag0_s  = tag_s;
        end else begin
          data1_s = rom_data;
          tag1_s  = tag_s;
        end
        count_s = count_s + 2'd1;
      end else begin
        count_s = count_s;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_WAIT;
      pc_r          <= PC_RESET_ALIGNED;
      count_r       <= 2'd0;
      data0_r       <= 32'h0000_0000;
      tag0_r        <= 32'h0000_0000;
      data1_r       <= 32'h0000_0000;
      tag1_r        <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      count_r       <= count_s;
      data0_r       <= data0_s;
      tag0_r        <= tag0_s;
      data1_r       <= data1_s;
      tag1_r        <= tag1_s;
      fetch_count_r <= fetch_count_s;
    end
  end

endmodule
